// File: rtl/chan_dec_pkg.sv
// Shared constants and FSM encoding for the channel-decoder coefficient scheduler.
// Pure declarations: no latency, no flow control.
package chan_dec_pkg;
  localparam int NUM_TAPS = 73;
  localparam int COEF_W   = 16;
  localparam int TAP_AW   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/chan_dec_rr_arbiter.sv
// Round-robin pick of the first set request at/after ptr, wrapping; combinational, 0 cycles.
// No backpressure: the caller samples grant/owner only when it is ready to start a sweep.
module chan_dec_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    owner,
  output logic               any_req
);
  logic found;

  assign any_req = |req;

  // Pass 1 scans from ptr upward; pass 2 wraps to the low indices.
  always_comb begin
    grant = '0;
    owner = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        owner    = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        owner    = ID_W'(j);
      end
    end
  end
endmodule

// File: rtl/channel_decoder_coef_sched.sv
// Streams one full coefficient ROM sweep per grant; first beat 2 cycles after req, done 1 cycle after last beat.
// Backpressure: coef_ready low freezes ROM reads so data and sideband hold; nothing is dropped.
module channel_decoder_coef_sched #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_TAPS = chan_dec_pkg::NUM_TAPS,
  parameter int DWIDTH   = chan_dec_pkg::COEF_W,
  parameter int AWIDTH   = chan_dec_pkg::TAP_AW,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic [AWIDTH-1:0]  rom_address0,
  output logic               rom_ce0,
  input  logic [DWIDTH-1:0]  rom_q0,
  output logic               coef_valid,
  input  logic               coef_ready,
  output logic [DWIDTH-1:0]  coef_data,
  output logic [AWIDTH-1:0]  coef_tap,
  output logic               coef_first,
  output logic               coef_last,
  output logic [ID_W-1:0]    coef_owner
);
  import chan_dec_pkg::*;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_TAPS - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t             state, state_nxt;
  logic [AWIDTH-1:0]  addr;
  logic [ID_W-1:0]    owner, rr_ptr, arb_owner;
  logic [NUM_REQ-1:0] arb_grant;
  logic               any_req, stall, xfer, ce, last_xfer;

  chan_dec_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (arb_grant),
    .owner   (arb_owner),
    .any_req (any_req)
  );

  assign stall        = coef_valid && !coef_ready;
  assign xfer         = coef_valid && coef_ready;
  assign ce           = (state == SWEEP) && !stall;
  assign last_xfer    = (state == DRAIN) && xfer && coef_last;
  assign rom_ce0      = ce;
  assign rom_address0 = addr;
  assign coef_data    = rom_q0;
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SWEEP;
      SWEEP:   if (ce && (addr == LAST_ADDR)) state_nxt = DRAIN;
      DRAIN:   if (last_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      done       <= '0;
      owner      <= '0;
      rr_ptr     <= '0;
      addr       <= '0;
      coef_valid <= 1'b0;
      coef_tap   <= '0;
      coef_first <= 1'b0;
      coef_last  <= 1'b0;
      coef_owner <= '0;
    end else begin
      state <= state_nxt;
      done  <= '0;
      if ((state == IDLE) && any_req) begin
        grant <= arb_grant;
        owner <= arb_owner;
        addr  <= '0;
      end
      // Sideband is captured alongside the read so it lines up with rom_q0 next cycle.
      if (ce) begin
        if (addr != LAST_ADDR) addr <= addr + 1'b1;
        coef_valid <= 1'b1;
        coef_tap   <= addr;
        coef_first <= (addr == '0);
        coef_last  <= (addr == LAST_ADDR);
        coef_owner <= owner;
      end else if (xfer) begin
        coef_valid <= 1'b0;
      end
      if (last_xfer) begin
        done   <= grant;
        grant  <= '0;
        rr_ptr <= (owner == LAST_ID) ? '0 : owner + 1'b1;
      end
    end
  end
endmodule
